// File: rtl/gate_bist_if.sv
// Bundle between a BIST tester and whoever controls it / owns the gate model.
// start is a level sampled only in IDLE or DONE; pattern_valid qualifies pattern_out; there is no back-pressure (no ready).
interface gate_bist_if #(
    parameter int PI_W = 11,
    parameter int PO_W = 10
);
    logic            start;
    logic            abort;
    logic [PO_W-1:0] expected_sig;
    logic [PO_W-1:0] response_in;
    logic [PI_W-1:0] pattern_out;
    logic            pattern_valid;
    logic            busy;
    logic            done;
    logic            pass;
    logic [PO_W-1:0] signature;

    modport master (
        output start, abort, expected_sig, response_in,
        input  pattern_out, pattern_valid, busy, done, pass, signature
    );

    modport slave (
        input  start, abort, expected_sig, response_in,
        output pattern_out, pattern_valid, busy, done, pass, signature
    );
endinterface

// File: rtl/gate_bist_tester.sv
// LFSR pattern generator + MISR response compactor for self-testing one combinational gate model.
// A run applies PATTERN_COUNT patterns, then compares the signature with expected_sig.
module gate_bist_tester #(
    parameter int          PI_W          = 11,
    parameter int          PO_W          = 10,
    parameter int          PATTERN_COUNT = 2047,
    parameter logic [10:0] LFSR_SEED     = 11'h001,
    parameter logic [9:0]  MISR_SEED     = 10'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_bist_if.slave  bus,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [11:0] LAST = 12'(PATTERN_COUNT - 1);

    state_t          state_q, state_n;
    logic [PI_W-1:0] lfsr_q, lfsr_n;
    logic [PO_W-1:0] misr_q, misr_n;
    logic [11:0]     count_q, count_n;
    logic            pass_q, pass_n;
    logic [PI_W-1:0] lfsr_step;
    logic [PO_W-1:0] misr_step;

    // x^11+x^9+1 and x^10+x^7+1; the response belongs to the pattern currently on pattern_out.
    assign lfsr_step = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    assign misr_step = {misr_q[8:0], misr_q[9] ^ misr_q[6]} ^ bus.response_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= MISR_SEED;
            count_q <= 12'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            lfsr_q  <= lfsr_n;
            misr_q  <= misr_n;
            count_q <= count_n;
            pass_q  <= pass_n;
        end
    end

    always_comb begin
        state_n = state_q;
        lfsr_n  = lfsr_q;
        misr_n  = misr_q;
        count_n = count_q;
        pass_n  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    lfsr_n  = LFSR_SEED;
                    misr_n  = MISR_SEED;
                    count_n = 12'd0;
                    pass_n  = 1'b0;
                end
            end
            RUN: begin
                // abort wins over completion; the partial signature stays visible.
                if (bus.abort) begin
                    state_n = IDLE;
                    lfsr_n  = LFSR_SEED;
                    pass_n  = 1'b0;
                end else begin
                    misr_n  = misr_step;
                    lfsr_n  = lfsr_step;
                    count_n = count_q + 12'd1;
                    if (count_q == LAST) begin
                        state_n = DONE;
                        pass_n  = (misr_step == bus.expected_sig);
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    lfsr_n  = LFSR_SEED;
                    misr_n  = MISR_SEED;
                    count_n = 12'd0;
                    pass_n  = 1'b0;
                end else if (bus.abort) begin
                    state_n = IDLE;
                    lfsr_n  = LFSR_SEED;
                    pass_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                lfsr_n  = LFSR_SEED;
                pass_n  = 1'b0;
            end
        endcase
    end

    assign bus.pattern_out   = lfsr_q;
    assign bus.signature     = misr_q;
    assign bus.pattern_valid = (state_q == RUN);
    assign bus.busy          = (state_q == RUN);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = pass_q;
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_gate_bist_tester.sv
// Bench for gate_bist_tester: a 12-pattern instance driven against a synthetic gate model,
// plus a 1-pattern instance for the shortest legal run.
module tb_gate_bist_tester;
  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   checks = 0;
  int   errors = 0;
  logic [20:0] exp_q[$];
  logic [1:0]  state_dbg, state_dbg1;

  gate_bist_if bus ();
  gate_bist_if bus1 ();

  gate_bist_tester #(.PATTERN_COUNT(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_dbg(state_dbg)
  );
  gate_bist_tester #(.PATTERN_COUNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .state_dbg(state_dbg1)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] lfsr_step(input logic [10:0] q);
    return {q[9:0], q[10] ^ q[8]};
  endfunction

  function automatic logic [9:0] misr_step(input logic [9:0] m, input logic [9:0] r);
    return {m[8:0], m[9] ^ m[6]} ^ r;
  endfunction

  // synthetic combinational gate model
  function automatic logic [9:0] gate_fn(input logic [10:0] p, input int m);
    case (m)
      0:       return 10'h000;
      1:       return 10'h001;
      default: return p[9:0] ^ p[10:1];
    endcase
  endfunction

  assign bus.response_in  = gate_fn(bus.pattern_out, mode);
  assign bus1.response_in = 10'h2a5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Push the model's per-cycle {pattern, signature} and run one full pass; called at a negedge.
  task automatic run_case(input int m, input bit good, output logic [9:0] sig_out);
    logic [10:0] p;
    logic [9:0]  s;
    logic [20:0] e;
    int          cyc;
    mode = m;
    p = 11'h001;
    s = 10'h000;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({p, s});
      s = misr_step(s, gate_fn(p, m));
      p = lfsr_step(p);
    end
    sig_out = s;
    bus.expected_sig = good ? s : (s ^ 10'h200);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      check_eq("pattern_valid", 32'(bus.pattern_valid), 1);
      if (exp_q.size() == 0) begin
        check_eq("run_len_overrun", cyc, 12);
        break;
      end
      e = exp_q.pop_front();
      check_eq("pattern_out", 32'(bus.pattern_out), 32'(e[20:10]));
      check_eq("sig_running", 32'(bus.signature), 32'(e[9:0]));
      cyc++;
      @(negedge clk);
    end
    check_eq("run_len", cyc, 12);
    check_eq("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check_eq("done", 32'(bus.done), 1);
    check_eq("busy_after", 32'(bus.busy), 0);
    check_eq("valid_after", 32'(bus.pattern_valid), 0);
    check_eq("signature", 32'(bus.signature), 32'(s));
    check_eq("pass", 32'(bus.pass), 32'(good));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_done"}, 32'(bus.done), 0);
    check_eq({tag, "_pass"}, 32'(bus.pass), 0);
    check_eq({tag, "_valid"}, 32'(bus.pattern_valid), 0);
    check_eq({tag, "_pattern"}, 32'(bus.pattern_out), 32'h001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  sig_a, sig_b, s2;
    logic [10:0] p;
    rst_n = 1'b0;
    mode = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expected_sig = 10'h000;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus1.expected_sig = 10'h2a5;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_sig", 32'(bus.signature), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero response, then accumulating constant response, then pattern-dependent response
    run_case(0, 1'b1, sig_a);
    run_case(1, 1'b1, sig_a);
    run_case(1, 1'b0, sig_a);
    run_case(2, 1'b1, sig_a);
    // restart straight from DONE must give the identical signature
    run_case(2, 1'b0, sig_b);
    check_eq("restart_same_sig", 32'(bus.signature), 32'(sig_a));

    // abort in DONE
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_done");

    // abort on the 3rd RUN cycle: two compactions done, the third is dropped
    mode = 2;
    p = 11'h001;
    s2 = misr_step(10'h000, gate_fn(p, 2));
    p = lfsr_step(p);
    s2 = misr_step(s2, gate_fn(p, 2));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_cycle3_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_run");
    check_eq("abort_partial_sig", 32'(bus.signature), 32'(s2));
    run_case(2, 1'b1, sig_b);
    check_eq("rerun_after_abort", 32'(bus.signature), 32'(sig_a));

    // reset on the 4th RUN cycle, with start toggling while in reset
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_cycle4_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check_idle("reset_mid");
    check_eq("reset_mid_sig", 32'(bus.signature), 0);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check_idle("reset_start_held");
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");

    // start and abort together in IDLE: start wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("start_over_abort", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("cleanup_abort");

    // PATTERN_COUNT=1: exactly one RUN cycle and one compaction
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check_eq("pc1_busy", 32'(bus1.busy), 1);
    check_eq("pc1_pattern", 32'(bus1.pattern_out), 32'h001);
    @(negedge clk);
    check_eq("pc1_busy_end", 32'(bus1.busy), 0);
    check_eq("pc1_done", 32'(bus1.done), 1);
    check_eq("pc1_sig", 32'(bus1.signature), 32'(misr_step(10'h000, 10'h2a5)));
    check_eq("pc1_pass", 32'(bus1.pass), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
